// File: rtl/ks_addsub_arbiter.sv
// Round-robin arbiter that shares one external Kogge-Stone adder among NREQ requesters.
// Each accepted request runs IDLE -> EXEC -> RESP and returns one tagged response.
module ks_addsub_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_op,
  input  logic [NREQ*N:1]   req_a,
  input  logic [NREQ*N:1]   req_b,
  output logic [N:1]        add_a,
  output logic [N:1]        add_b,
  output logic              add_cin,
  input  logic [N:1]        add_s,
  input  logic              add_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N:1]        rsp_sum,
  output logic              rsp_cout,
  output logic              rsp_ovf
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant;
  logic           found;
  logic [N:1]     op_a;
  logic [N:1]     op_b;
  logic           op_cin;
  logic [N:1]     sel_a;
  logic [N:1]     sel_b;

  // Rotating priority: first valid requester at or after ptr, wrapping around.
  always_comb begin
    int idx;
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      req_ready[i] = !reset && (state == IDLE) && found && (grant == IDW'(i));
  end

  assign sel_a   = req_a[int'(grant)*N+1 +: N];
  assign sel_b   = req_b[int'(grant)*N+1 +: N];
  assign add_a   = op_a;
  assign add_b   = op_b;
  assign add_cin = op_cin;

  // Subtract is issued as A + ~B + 1, so operands are conditioned at acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_a   <= sel_a;
            op_b   <= req_op[grant] ? ~sel_b : sel_b;
            op_cin <= req_op[grant];
            rsp_id <= grant;
            ptr    <= (grant == IDW'(NREQ-1)) ? '0 : grant + IDW'(1);
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum   <= add_s;
          rsp_cout  <= add_cout;
          rsp_ovf   <= (op_a[N] == op_b[N]) & (add_s[N] != op_a[N]);
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
